// File: rtl/memory_bus_arbiter.sv
// Two-master round-robin arbiter in front of the memory controller's single port.
// One transaction in flight; request fields latched at grant; a watchdog turns a missing ACK into ERR.
module memory_bus_arbiter #(
    parameter int unsigned BYTE_AMNT      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,

    input  logic                   inst_STB_I,
    input  logic [8*BYTE_AMNT-1:0] inst_ADR_I,
    output logic [8*BYTE_AMNT-1:0] inst_DAT_O,
    output logic                   inst_ACK_O,
    output logic                   inst_ERR_O,

    input  logic                   data_STB_I,
    input  logic                   data_WE_I,
    input  logic [BYTE_AMNT-1:0]   data_SEL_I,
    input  logic [8*BYTE_AMNT-1:0] data_ADR_I,
    input  logic [8*BYTE_AMNT-1:0] data_DAT_I,
    output logic [8*BYTE_AMNT-1:0] data_DAT_O,
    output logic                   data_ACK_O,
    output logic                   data_ERR_O,

    output logic                   mem_STB_O,
    output logic                   mem_WE_O,
    output logic [BYTE_AMNT-1:0]   mem_SEL_O,
    output logic [8*BYTE_AMNT-1:0] mem_ADR_O,
    output logic [8*BYTE_AMNT-1:0] mem_DAT_O,
    input  logic [8*BYTE_AMNT-1:0] mem_DAT_I,
    input  logic                   mem_ACK_I
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TimerSat  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StGntInst, StGntData} state_t;

    state_t          state_q;
    logic            prio_data_q;
    logic [TW-1:0]   timer_q;

    logic            gnt_inst;
    logic            gnt_data;
    logic            timeout;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= StIdle;
            prio_data_q <= 1'b1;
            timer_q     <= '0;
            mem_STB_O   <= 1'b0;
            mem_WE_O    <= 1'b0;
            mem_SEL_O   <= '0;
            mem_ADR_O   <= '0;
            mem_DAT_O   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Data wins when it holds priority or fetch is not asking.
                    if (data_STB_I && (prio_data_q || !inst_STB_I)) begin
                        state_q     <= StGntData;
                        prio_data_q <= 1'b0;
                        timer_q     <= '0;
                        mem_STB_O   <= 1'b1;
                        mem_WE_O    <= data_WE_I;
                        mem_SEL_O   <= data_SEL_I;
                        mem_ADR_O   <= data_ADR_I;
                        mem_DAT_O   <= data_DAT_I;
                    end else if (inst_STB_I) begin
                        state_q     <= StGntInst;
                        prio_data_q <= 1'b1;
                        timer_q     <= '0;
                        mem_STB_O   <= 1'b1;
                        mem_WE_O    <= 1'b0;
                        mem_SEL_O   <= '1;
                        mem_ADR_O   <= inst_ADR_I;
                        mem_DAT_O   <= '0;
                    end
                end
                StGntInst, StGntData: begin
                    if (mem_ACK_I || timer_q == TimerLast) begin
                        state_q   <= StIdle;
                        mem_STB_O <= 1'b0;
                    end else if (timer_q != TimerSat) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_STB_O <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_inst = (state_q == StGntInst);
    assign gnt_data = (state_q == StGntData);
    // An ACK arriving in the final watchdog cycle takes precedence over the error.
    assign timeout  = !mem_ACK_I && (timer_q == TimerLast);

    assign inst_ACK_O = gnt_inst && mem_ACK_I;
    assign inst_ERR_O = gnt_inst && timeout;
    assign inst_DAT_O = inst_ACK_O ? mem_DAT_I : '0;

    assign data_ACK_O = gnt_data && mem_ACK_I;
    assign data_ERR_O = gnt_data && timeout;
    assign data_DAT_O = data_ACK_O ? mem_DAT_I : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed and randomized checks of memory_bus_arbiter against a transaction-level model.
module tb_memory_bus_arbiter;

    localparam int B = 4;
    localparam int T = 4;
    localparam int W = 8 * B;

    logic         CLK_I;
    logic         RST_I;
    logic         inst_STB_I;
    logic [W-1:0] inst_ADR_I;
    logic [W-1:0] inst_DAT_O;
    logic         inst_ACK_O;
    logic         inst_ERR_O;
    logic         data_STB_I;
    logic         data_WE_I;
    logic [B-1:0] data_SEL_I;
    logic [W-1:0] data_ADR_I;
    logic [W-1:0] data_DAT_I;
    logic [W-1:0] data_DAT_O;
    logic         data_ACK_O;
    logic         data_ERR_O;
    logic         mem_STB_O;
    logic         mem_WE_O;
    logic [B-1:0] mem_SEL_O;
    logic [W-1:0] mem_ADR_O;
    logic [W-1:0] mem_DAT_O;
    logic [W-1:0] mem_DAT_I;
    logic         mem_ACK_I;

    memory_bus_arbiter #(
        .BYTE_AMNT     (B),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .inst_STB_I(inst_STB_I),
        .inst_ADR_I(inst_ADR_I),
        .inst_DAT_O(inst_DAT_O),
        .inst_ACK_O(inst_ACK_O),
        .inst_ERR_O(inst_ERR_O),
        .data_STB_I(data_STB_I),
        .data_WE_I (data_WE_I),
        .data_SEL_I(data_SEL_I),
        .data_ADR_I(data_ADR_I),
        .data_DAT_I(data_DAT_I),
        .data_DAT_O(data_DAT_O),
        .data_ACK_O(data_ACK_O),
        .data_ERR_O(data_ERR_O),
        .mem_STB_O (mem_STB_O),
        .mem_WE_O  (mem_WE_O),
        .mem_SEL_O (mem_SEL_O),
        .mem_ADR_O (mem_ADR_O),
        .mem_DAT_O (mem_DAT_O),
        .mem_DAT_I (mem_DAT_I),
        .mem_ACK_I (mem_ACK_I)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int total;
    int bad;

    // Transaction-level model: who owns the bus (0 none, 1 fetch, 2 data), how long it
    // has waited, who is favoured next, and what was captured at grant time.
    int           owner;
    int           waited;
    int           favour;
    int           done_side;
    logic         l_we;
    logic [B-1:0] l_sel;
    logic [W-1:0] l_adr;
    logic [W-1:0] l_dat;
    int           ack_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        owner     = 0;
        waited    = 0;
        favour    = 2;
        done_side = 0;
        l_we      = 1'b0;
        l_sel     = '0;
        l_adr     = '0;
        l_dat     = '0;
    endtask

    // Let inputs settle, then compare every output with the model's view of this cycle.
    task automatic settle();
        logic late;
        logic a_i;
        logic a_d;
        #1;
        late = (waited == T - 1) && !mem_ACK_I;
        a_i  = (owner == 1) && mem_ACK_I;
        a_d  = (owner == 2) && mem_ACK_I;
        chk("mem_stb", mem_STB_O, owner != 0);
        chk("mem_we", mem_WE_O, l_we);
        chk("mem_sel", mem_SEL_O, l_sel);
        chk("mem_adr", mem_ADR_O, l_adr);
        chk("mem_dat", mem_DAT_O, l_dat);
        chk("inst_ack", inst_ACK_O, a_i);
        chk("inst_err", inst_ERR_O, (owner == 1) && late);
        chk("inst_dat", inst_DAT_O, a_i ? mem_DAT_I : '0);
        chk("data_ack", data_ACK_O, a_d);
        chk("data_err", data_ERR_O, (owner == 2) && late);
        chk("data_dat", data_DAT_O, a_d ? mem_DAT_I : '0);
        if (inst_ACK_O === 1'b1) ack_log.push_back(1);
        if (data_ACK_O === 1'b1) ack_log.push_back(2);
    endtask

    // Advance one clock edge and apply the arbitration rules to the model.
    task automatic tick();
        @(posedge CLK_I);
        done_side = 0;
        if (owner == 0) begin
            if (data_STB_I && (favour == 2 || !inst_STB_I)) begin
                owner  = 2;
                favour = 1;
                waited = 0;
                l_we   = data_WE_I;
                l_sel  = data_SEL_I;
                l_adr  = data_ADR_I;
                l_dat  = data_DAT_I;
            end else if (inst_STB_I) begin
                owner  = 1;
                favour = 2;
                waited = 0;
                l_we   = 1'b0;
                l_sel  = '1;
                l_adr  = inst_ADR_I;
                l_dat  = '0;
            end
        end else if (mem_ACK_I || waited == T - 1) begin
            done_side = owner;
            owner     = 0;
        end else begin
            waited++;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    // Assert reset between edges and check its effect without waiting for the clock.
    task automatic do_reset();
        RST_I = 1'b1;
        model_reset();
        settle();
        repeat (2) @(posedge CLK_I);
        #3;
        RST_I = 1'b0;
    endtask

    initial begin
        int i_pend;
        int d_pend;
        total      = 0;
        bad        = 0;
        inst_STB_I = 1'b0;
        inst_ADR_I = '0;
        data_STB_I = 1'b0;
        data_WE_I  = 1'b0;
        data_SEL_I = '0;
        data_ADR_I = '0;
        data_DAT_I = '0;
        mem_DAT_I  = '0;
        mem_ACK_I  = 1'b0;
        do_reset();

        // Fetch with ACK in the second granted cycle.
        inst_STB_I = 1'b1;
        inst_ADR_I = 32'h0000_1000;
        cyc();
        settle();
        chk("t1_sel", mem_SEL_O, 4'hF);
        chk("t1_we", mem_WE_O, 1'b0);
        chk("t1_adr", mem_ADR_O, 32'h0000_1000);
        tick();
        mem_ACK_I = 1'b1;
        mem_DAT_I = 32'hDEAD_BEEF;
        settle();
        chk("t1_ack", inst_ACK_O, 1'b1);
        chk("t1_dat", inst_DAT_O, 32'hDEAD_BEEF);
        tick();
        inst_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        settle();
        chk("t1_ack_pulse", inst_ACK_O, 1'b0);
        tick();

        // Both masters hold requests from reset: grants must alternate starting with data.
        do_reset();
        ack_log.delete();
        inst_STB_I = 1'b1;
        data_STB_I = 1'b1;
        data_ADR_I = 32'h0000_0200;
        for (int i = 0; i < 20; i++) begin
            mem_ACK_I = (owner != 0);
            mem_DAT_I = $urandom;
            cyc();
        end
        chk("t2_count", ack_log.size(), 10);
        for (int i = 0; i < ack_log.size(); i++) begin
            chk("t2_order", ack_log[i], (i % 2 == 0) ? 2 : 1);
        end
        inst_STB_I = 1'b0;
        data_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        cyc();

        // Store whose inputs change after grant.
        data_STB_I = 1'b1;
        data_WE_I  = 1'b1;
        data_SEL_I = 4'h0F;
        data_ADR_I = 32'h0100_0008;
        data_DAT_I = 32'h0000_0055;
        cyc();
        data_DAT_I = 32'h0000_00AA;
        data_ADR_I = 32'h0;
        data_SEL_I = 4'h0;
        data_WE_I  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t3_dat", mem_DAT_O, 32'h0000_0055);
            chk("t3_we", mem_WE_O, 1'b1);
            chk("t3_adr", mem_ADR_O, 32'h0100_0008);
            tick();
        end
        mem_ACK_I = 1'b1;
        settle();
        chk("t3_ack", data_ACK_O, 1'b1);
        chk("t3_we_ack", mem_WE_O, 1'b1);
        tick();
        data_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        cyc();

        // Data read with no ACK times out; a fetch waiting behind it then proceeds.
        data_STB_I = 1'b1;
        data_WE_I  = 1'b0;
        data_ADR_I = 32'hDEAD_0000;
        cyc();
        inst_STB_I = 1'b1;
        inst_ADR_I = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_err", data_ERR_O, k == 3);
            chk("t4_noack", data_ACK_O, 1'b0);
            tick();
        end
        data_STB_I = 1'b0;
        settle();
        chk("t4_gap", mem_STB_O, 1'b0);
        tick();
        mem_ACK_I = 1'b1;
        settle();
        chk("t4_inst_adr", mem_ADR_O, 32'h0000_2000);
        chk("t4_inst_ack", inst_ACK_O, 1'b1);
        tick();
        inst_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        cyc();

        // ACK lands in the final watchdog cycle.
        inst_STB_I = 1'b1;
        inst_ADR_I = 32'h0000_3000;
        cyc();
        repeat (3) cyc();
        mem_ACK_I = 1'b1;
        mem_DAT_I = 32'h1234_5678;
        settle();
        chk("t5_ack", inst_ACK_O, 1'b1);
        chk("t5_err", inst_ERR_O, 1'b0);
        tick();
        inst_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        cyc();

        // Reset in the middle of a fetch, then contention right after release.
        inst_STB_I = 1'b1;
        inst_ADR_I = 32'h0000_4000;
        cyc();
        cyc();
        mem_ACK_I = 1'b1;
        mem_DAT_I = 32'hFFFF_FFFF;
        do_reset();
        chk("t6_stb", mem_STB_O, 1'b0);
        chk("t6_adr", mem_ADR_O, 32'h0);
        mem_ACK_I  = 1'b0;
        data_STB_I = 1'b1;
        data_ADR_I = 32'h0000_5000;
        cyc();
        mem_ACK_I = 1'b1;
        settle();
        chk("t6_first_adr", mem_ADR_O, 32'h0000_5000);
        chk("t6_first_ack", data_ACK_O, 1'b1);
        tick();
        inst_STB_I = 1'b0;
        data_STB_I = 1'b0;
        mem_ACK_I  = 1'b0;
        cyc();

        // Randomized traffic: masters hold requests until done, memory answers late or never.
        i_pend = 0;
        d_pend = 0;
        for (int n = 0; n < 400; n++) begin
            if (done_side == 1) i_pend = 0;
            if (done_side == 2) d_pend = 0;
            if (i_pend == 0 && $urandom_range(0, 2) == 0) begin
                i_pend     = 1;
                inst_ADR_I = $urandom;
            end
            if (d_pend == 0 && $urandom_range(0, 2) == 0) begin
                d_pend     = 1;
                data_ADR_I = $urandom;
                data_DAT_I = $urandom;
                data_SEL_I = B'($urandom);
                data_WE_I  = 1'($urandom);
            end
            if (owner != 0 && $urandom_range(0, 3) == 0) begin
                inst_ADR_I = $urandom;
                data_DAT_I = $urandom;
            end
            inst_STB_I = (i_pend != 0);
            data_STB_I = (d_pend != 0);
            mem_ACK_I  = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            mem_DAT_I  = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
